// File: rtl/channel_fifo.sv
// channel_fifo: DEPTH-entry flit buffer on a router output channel with req/ack on both sides
// and a count of completed FLITS-flit packets leaving the buffer.
module channel_fifo #(
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2,
  parameter int FLIT_BITS = 8,
  parameter int FLITS     = 8,
  parameter int ID        = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req,
  input  logic [FLIT_BITS-1:0] in_flit,
  output logic                 in_ack,
  output logic                 out_req,
  output logic [FLIT_BITS-1:0] out_flit,
  input  logic                 out_ack,
  output logic [ADDR_BITS:0]   level,
  output logic                 pkt_done,
  output logic [15:0]          pkts_out
);
  localparam int IW = FLITS > 1 ? $clog2(FLITS) : 1;
  if (DEPTH < 2 || DEPTH != (1 << ADDR_BITS) || FLITS < 1 || ID < 0) begin : g_bad_params
    $error("channel_fifo: DEPTH must be 2**ADDR_BITS and >= 2, FLITS >= 1, ID >= 0");
  end
  logic [FLIT_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [IW-1:0]        flit_idx;
  logic                 push, pop, last;
  // all outputs decode registered state only, so no input-to-output combinational path
  always_comb begin
    in_ack   = count != (ADDR_BITS+1)'(DEPTH);
    out_req  = count != '0;
    out_flit = out_req ? mem[rd_ptr] : '0;
    level    = count;
    push     = in_req && in_ack;
    pop      = out_req && out_ack;
    last     = flit_idx == IW'(FLITS-1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      flit_idx <= '0;
      pkts_out <= '0;
      pkt_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      if (pop) flit_idx <= last ? '0 : flit_idx + 1'b1;
      if (pop && last) pkts_out <= pkts_out + 1'b1;
      pkt_done <= pop && last;
    end
  end
  // storage is deliberately not reset; stale entries are unreachable once count is 0
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end
endmodule
